// File: rtl/ax_eval_pkg.sv
// Shared constants, state encoding and shift-add helper for the A*x residual evaluator.
package ax_eval_pkg;

  localparam int unsigned FRAC = 16;
  localparam int unsigned XW   = 32;
  localparam int unsigned AXW  = 38;
  localparam int unsigned RW   = 39;
  localparam int unsigned BW   = 16;

  localparam logic [4:0] C1  = 5'd1;
  localparam logic [4:0] C6  = 5'd6;
  localparam logic [4:0] C13 = 5'd13;
  localparam logic [4:0] C20 = 5'd20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_e;

  // Constant coefficient times v as a sum of shifted copies (k is always a constant).
  function automatic logic signed [AXW-1:0] shift_add(input logic signed [AXW-1:0] v,
                                                      input logic [4:0] k);
    logic signed [AXW-1:0] acc;
    acc = '0;
    for (int b = 0; b < 5; b++) begin
      if (k[b]) acc = acc + (v <<< b);
    end
    return acc;
  endfunction

endpackage

// File: rtl/ax_eval_row.sv
// Seven-tap banded row product: 20*x0 - (x-1+x+1) + 6*(x-2+x+2) - 13*(x-3+x+3).
module ax_row
  import ax_eval_pkg::*;
(
  input  logic signed [XW-1:0]  x_m3,
  input  logic signed [XW-1:0]  x_m2,
  input  logic signed [XW-1:0]  x_m1,
  input  logic signed [XW-1:0]  x_0,
  input  logic signed [XW-1:0]  x_p1,
  input  logic signed [XW-1:0]  x_p2,
  input  logic signed [XW-1:0]  x_p3,
  output logic signed [AXW-1:0] ax
);

  logic signed [AXW-1:0] s0, s1, s2, s3;

  // Symmetric pairs are summed at full width first so no partial sum can wrap.
  always_comb begin
    s0 = AXW'(x_0);
    s1 = AXW'(x_m1) + AXW'(x_p1);
    s2 = AXW'(x_m2) + AXW'(x_p2);
    s3 = AXW'(x_m3) + AXW'(x_p3);
    ax = shift_add(s0, C20) - shift_add(s1, C1) + shift_add(s2, C6) - shift_add(s3, C13);
  end

endmodule

// File: rtl/ax_eval.sv
// Streaming residual r = b*2^16 - A*x for a banded 7-diagonal A, with per-frame max |r|.
module ax_eval
  import ax_eval_pkg::*;
#(
  parameter int unsigned     N   = 16,
  parameter logic [RW-1:0]   TOL = 39'd64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [XW-1:0]     in_x,
  input  logic signed [BW-1:0]     in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(N)-1:0]     out_idx,
  output logic signed [AXW-1:0]    out_ax,
  output logic signed [RW-1:0]     out_r,
  output logic                     done,
  output logic [RW-1:0]            max_abs_r,
  output logic                     converged
);

  localparam int unsigned IW = $clog2(N);

  state_e                 state_q;
  logic signed [XW-1:0]   win_q [7];
  logic signed [BW-1:0]   bd_q  [3];
  logic [IW-1:0]          cnt_q, nidx_q;
  logic [1:0]             fcnt_q;
  logic                   iss_v_q, s1_v_q, out_v_q;
  logic [IW-1:0]          iss_idx_q, s1_idx_q, out_idx_q;
  logic signed [BW-1:0]   iss_b_q, s1_b_q;
  logic signed [AXW-1:0]  s1_ax_q, out_ax_q;
  logic signed [RW-1:0]   out_r_q;
  logic [RW-1:0]          max_q;
  logic                   conv_q, done_q;

  logic                   stall_c, adv_c, acc_c, fl_c, shift_c, issue_c, xfer_c;
  logic signed [XW-1:0]   sh_x_c;
  logic signed [BW-1:0]   sh_b_c;
  logic signed [AXW-1:0]  ax_c;
  logic signed [RW-1:0]   r_c;
  logic [RW-1:0]          abs_c;

  ax_row u_row (
    .x_m3 (win_q[0]),
    .x_m2 (win_q[1]),
    .x_m1 (win_q[2]),
    .x_0  (win_q[3]),
    .x_p1 (win_q[4]),
    .x_p2 (win_q[5]),
    .x_p3 (win_q[6]),
    .ax   (ax_c)
  );

  // A held output result freezes every stage behind it.
  always_comb begin
    stall_c = out_v_q && !out_ready;
    adv_c   = !stall_c;
    acc_c   = in_valid && in_ready;
    fl_c    = (state_q == S_FLUSH) && (fcnt_q != 2'd3) && adv_c;
    shift_c = acc_c || fl_c;
    issue_c = shift_c && (state_q != S_FILL);
    sh_x_c  = fl_c ? '0 : in_x;
    sh_b_c  = fl_c ? '0 : in_b;
    xfer_c  = out_v_q && out_ready;
    r_c     = (RW'(s1_b_q) <<< FRAC) - RW'(s1_ax_q);
    abs_c   = out_r_q[RW-1] ? RW'(-out_r_q) : RW'(out_r_q);
  end

  assign in_ready  = ((state_q == S_FILL) || (state_q == S_RUN)) && !stall_c;
  assign out_valid = out_v_q;
  assign out_idx   = out_idx_q;
  assign out_ax    = out_ax_q;
  assign out_r     = out_r_q;
  assign done      = done_q;
  assign max_abs_r = max_q;
  assign converged = conv_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      for (int k = 0; k < 7; k++) win_q[k] <= '0;
      for (int k = 0; k < 3; k++) bd_q[k]  <= '0;
      cnt_q     <= '0;
      nidx_q    <= '0;
      fcnt_q    <= '0;
      iss_v_q   <= 1'b0;
      iss_idx_q <= '0;
      iss_b_q   <= '0;
      s1_v_q    <= 1'b0;
      s1_idx_q  <= '0;
      s1_ax_q   <= '0;
      s1_b_q    <= '0;
      out_v_q   <= 1'b0;
      out_idx_q <= '0;
      out_ax_q  <= '0;
      out_r_q   <= '0;
      max_q     <= '0;
      conv_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (adv_c) begin
        iss_v_q <= issue_c;
        if (issue_c) begin
          iss_idx_q <= nidx_q;
          iss_b_q   <= bd_q[0];
          nidx_q    <= nidx_q + IW'(1);
        end
        s1_v_q <= iss_v_q;
        if (iss_v_q) begin
          s1_idx_q <= iss_idx_q;
          s1_ax_q  <= ax_c;
          s1_b_q   <= iss_b_q;
        end
        out_v_q <= s1_v_q;
        if (s1_v_q) begin
          out_idx_q <= s1_idx_q;
          out_ax_q  <= s1_ax_q;
          out_r_q   <= r_c;
        end
      end

      // Newest sample enters at the top; b lags three shifts to line up with its row.
      if (shift_c) begin
        for (int k = 0; k < 6; k++) win_q[k] <= win_q[k+1];
        win_q[6] <= sh_x_c;
        bd_q[0]  <= bd_q[1];
        bd_q[1]  <= bd_q[2];
        bd_q[2]  <= sh_b_c;
      end

      if (xfer_c && (abs_c > max_q)) max_q <= abs_c;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_FILL;
            for (int k = 0; k < 7; k++) win_q[k] <= '0;
            for (int k = 0; k < 3; k++) bd_q[k]  <= '0;
            cnt_q  <= '0;
            nidx_q <= '0;
            fcnt_q <= '0;
            max_q  <= '0;
            conv_q <= 1'b0;
          end
        end
        S_FILL: begin
          if (acc_c) begin
            cnt_q <= cnt_q + IW'(1);
            if (cnt_q == IW'(2)) state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (acc_c) begin
            cnt_q <= cnt_q + IW'(1);
            if (cnt_q == IW'(N - 1)) state_q <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (fl_c) fcnt_q <= fcnt_q + 2'd1;
          if ((fcnt_q == 2'd3) && !iss_v_q && !s1_v_q && xfer_c) state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b1;
          conv_q  <= (max_q <= TOL);
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
